// File: rtl/tmds_channel_decoder_pkg.sv
// tmds_channel_decoder_pkg: shared constants and types for the TMDS channel decoder.
//   CTRL_00..CTRL_11 : the four control tokens, named by their c1c0 value.
//   state_t          : alignment FSM states.
//   OFFSET_W         : width of the bit-offset register (offsets 0..9).
package tmds_channel_decoder_pkg;

    localparam int OFFSET_W = 4;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational decode of one aligned 10-bit TMDS symbol.
//   i_sym     : aligned symbol, i_sym[0] earliest bit on the wire
//   o_is_ctrl : symbol is one of the four control tokens
//   o_c0/o_c1 : control bits carried by the token (0 for data symbols)
//   o_d       : decoded 8-bit data (meaningful only when o_is_ctrl is 0)
module tmds_symbol_decode
    import tmds_channel_decoder_pkg::*;
(
    input  logic [9:0] i_sym,
    output logic       o_is_ctrl,
    output logic       o_c0,
    output logic       o_c1,
    output logic [7:0] o_d
);

    logic [7:0] w_t;

    // bit 9 flags DC-balance inversion, bit 8 selects XOR (1) or XNOR (0) chaining
    assign w_t = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];
    assign o_d = {w_t[7:1] ^ w_t[6:0] ^ {7{~i_sym[8]}}, w_t[0]};

    assign o_c0      = (i_sym == CTRL_01) || (i_sym == CTRL_11);
    assign o_c1      = (i_sym == CTRL_10) || (i_sym == CTRL_11);
    assign o_is_ctrl = (i_sym == CTRL_00) || o_c0 || o_c1;

endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: aligns and decodes one TMDS channel from raw deserialized words.
//   i_pixelclk : pixel clock, all logic on the rising edge
//   i_rst_n    : synchronous active-low reset
//   i_din      : raw 10-bit word, i_din[0] earliest bit
//   o_dout     : decoded pixel data (0 for tokens and while unlocked)
//   o_de       : 1 for data symbols, 0 for control tokens
//   o_c0/o_c1  : control-token bits
//   o_locked   : symbol alignment achieved
//   o_offset   : current bit offset 0..9
//   o_err_cnt  : loss-of-lock count when TMDS_DEC_ERR_CNT_EN is defined, else 0
// Optional feature macro: TMDS_DEC_ERR_CNT_EN
module tmds_channel_decoder
    import tmds_channel_decoder_pkg::*;
#(
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOCK_CNT       = 8
) (
    input  logic                i_pixelclk,
    input  logic                i_rst_n,
    input  logic [9:0]          i_din,
    output logic [7:0]          o_dout,
    output logic                o_de,
    output logic                o_c0,
    output logic                o_c1,
    output logic                o_locked,
    output logic [OFFSET_W-1:0] o_offset,
    output logic [15:0]         o_err_cnt
);

    localparam int IDLE_W = $clog2(SEARCH_TIMEOUT + 1);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);

    logic [9:0]          r_din_prev;
    logic [9:0]          r_sym;
    logic [OFFSET_W-1:0] r_offset;
    state_t              r_state;
    logic [IDLE_W-1:0]   r_idle_cnt;
    logic [RUN_W-1:0]    r_run_cnt;
    logic [7:0]          r_dout;
    logic                r_de;
    logic                r_c0;
    logic                r_c1;

    logic [18:0]         w_win;
    logic [9:0]          w_sym;
    logic                w_is_ctrl;
    logic                w_c0;
    logic                w_c1;
    logic [7:0]          w_d;
    logic                w_timeout;
    logic                w_lock_hit;
    logic                w_next_locked;

    // the top bit of the new word never lands in a symbol at offsets 0..9
    assign w_win = {i_din[8:0], r_din_prev};

    always_comb begin
        w_sym = w_win[9:0];
        for (int k = 1; k < 10; k++)
            if (r_offset == OFFSET_W'(k)) w_sym = w_win[k +: 10];
    end

    tmds_symbol_decode u_decode (
        .i_sym     (r_sym),
        .o_is_ctrl (w_is_ctrl),
        .o_c0      (w_c0),
        .o_c1      (w_c1),
        .o_d       (w_d)
    );

    // a token on the would-be timeout cycle suppresses the timeout
    assign w_timeout     = !w_is_ctrl && (r_idle_cnt == IDLE_W'(SEARCH_TIMEOUT - 1));
    assign w_lock_hit    = (r_state == ST_SEARCH) && w_is_ctrl && (r_run_cnt == RUN_W'(LOCK_CNT - 1));
    assign w_next_locked = (r_state == ST_LOCKED) ? !w_timeout : w_lock_hit;

    always_ff @(posedge i_pixelclk) begin
        if (!i_rst_n) begin
            r_din_prev <= '0;
            r_sym      <= '0;
            r_offset   <= '0;
            r_state    <= ST_SEARCH;
            r_idle_cnt <= '0;
            r_run_cnt  <= '0;
            r_dout     <= '0;
            r_de       <= 1'b0;
            r_c0       <= 1'b0;
            r_c1       <= 1'b0;
        end else begin
            r_din_prev <= i_din;
            r_sym      <= w_sym;
            r_idle_cnt <= (w_is_ctrl || w_timeout) ? '0 : r_idle_cnt + 1'b1;
            r_run_cnt  <= (r_state == ST_SEARCH && w_is_ctrl && !w_lock_hit) ? r_run_cnt + 1'b1 : '0;
            if (r_state == ST_SEARCH && w_timeout)
                r_offset <= (r_offset == OFFSET_W'(9)) ? '0 : r_offset + 1'b1;
            r_state    <= w_next_locked ? ST_LOCKED : ST_SEARCH;
            // outputs follow the next state so the locking token is itself emitted
            r_de       <= w_next_locked && !w_is_ctrl;
            r_c0       <= w_next_locked && w_is_ctrl && w_c0;
            r_c1       <= w_next_locked && w_is_ctrl && w_c1;
            r_dout     <= (w_next_locked && !w_is_ctrl) ? w_d : '0;
        end
    end

    assign o_dout   = r_dout;
    assign o_de     = r_de;
    assign o_c0     = r_c0;
    assign o_c1     = r_c1;
    assign o_locked = (r_state == ST_LOCKED);
    assign o_offset = r_offset;

`ifdef TMDS_DEC_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge i_pixelclk) begin
        if (!i_rst_n)
            r_err_cnt <= '0;
        else if (r_state == ST_LOCKED && w_timeout && r_err_cnt != 16'hFFFF)
            r_err_cnt <= r_err_cnt + 1'b1;
    end

    assign o_err_cnt = r_err_cnt;
`else
    assign o_err_cnt = '0;
`endif

endmodule
